// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: compare-op encoding and
// instruction size.
package branch_resolve_unit_pkg;

    typedef enum logic [2:0] {
        CMP_NOP = 3'd0,
        CMP_EQ  = 3'd1,
        CMP_NE  = 3'd2,
        CMP_LT  = 3'd3,
        CMP_GE  = 3'd4,
        CMP_LTU = 3'd5,
        CMP_GEU = 3'd6
    } alu_cmp_op_e;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/branch_resolve_unit_compare.sv
// Combinational branch condition evaluator; NOP and unused codes resolve to
// not-taken.
module branch_compare
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      i_cmp_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_taken
);

    alu_cmp_op_e w_op;

    assign w_op = alu_cmp_op_e'(i_cmp_op);

    always_comb begin
        o_taken = 1'b0;
        case (w_op)
            CMP_EQ:  o_taken = (i_a == i_b);
            CMP_NE:  o_taken = (i_a != i_b);
            CMP_LT:  o_taken = ($signed(i_a) <  $signed(i_b));
            CMP_GE:  o_taken = ($signed(i_a) >= $signed(i_b));
            CMP_LTU: o_taken = (i_a <  i_b);
            CMP_GEU: o_taken = (i_a >= i_b);
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: one registered stage with valid/ready on
// both sides, mispredict redirect pulse and saturating perf counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_cmp_op,
    input  logic [XLEN-1:0]  in_rs1_val,
    input  logic [XLEN-1:0]  in_rs2_val,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             in_pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_next_pc,
    output logic             out_misalign,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt_resolved,
    output logic [CNT_W-1:0] cnt_mispredict
);

    logic             r_valid;
    logic             r_taken;
    logic [XLEN-1:0]  r_target;
    logic [XLEN-1:0]  r_next_pc;
    logic             r_misalign;
    logic             r_pred;
    logic             r_redirect_valid;
    logic [XLEN-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_cnt_res;
    logic [CNT_W-1:0] r_cnt_mis;

    logic             w_taken;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_fall;
    logic             w_accept;
    logic             w_hs;
    logic             w_mispred;

    branch_compare #(.XLEN(XLEN)) u_cmp (
        .i_cmp_op (in_cmp_op),
        .i_a      (in_rs1_val),
        .i_b      (in_rs2_val),
        .o_taken  (w_taken)
    );

    assign w_target  = in_pc + in_imm;
    assign w_fall    = in_pc + XLEN'(INSTR_BYTES);
    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_hs      = r_valid && out_ready && !flush;
    // Misaligned targets trap later, so they never redirect fetch.
    assign w_mispred = w_hs && !r_misalign && (r_taken != r_pred);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid          <= 1'b0;
            r_taken          <= 1'b0;
            r_target         <= '0;
            r_next_pc        <= '0;
            r_misalign       <= 1'b0;
            r_pred           <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_cnt_res        <= '0;
            r_cnt_mis        <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid    <= 1'b1;
                r_taken    <= w_taken;
                r_target   <= w_target;
                r_next_pc  <= w_taken ? w_target : w_fall;
                r_misalign <= w_taken && (w_target[1:0] != 2'b00);
                r_pred     <= in_pred_taken;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end

            r_redirect_valid <= w_mispred;
            if (w_mispred) begin
                r_redirect_pc <= r_next_pc;
            end

            if (w_hs && (r_cnt_res != '1)) begin
                r_cnt_res <= r_cnt_res + CNT_W'(1);
            end
            if (w_mispred && (r_cnt_mis != '1)) begin
                r_cnt_mis <= r_cnt_mis + CNT_W'(1);
            end
        end
    end

    assign out_valid      = r_valid;
    assign out_taken      = r_taken;
    assign out_target     = r_target;
    assign out_next_pc    = r_next_pc;
    assign out_misalign   = r_misalign;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign cnt_resolved   = r_cnt_res;
    assign cnt_mispredict = r_cnt_mis;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a scoreboard of resolved
// entries, plus a 4-bit-counter instance for saturation.
module tb_branch_resolve_unit;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_EQ  = 3'd1;
    localparam logic [2:0] OP_NE  = 3'd2;
    localparam logic [2:0] OP_LT  = 3'd3;
    localparam logic [2:0] OP_GE  = 3'd4;
    localparam logic [2:0] OP_LTU = 3'd5;
    localparam logic [2:0] OP_GEU = 3'd6;
    localparam logic [2:0] OP_BAD = 3'd7;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_pred_taken, out_ready, flush;
    logic [2:0]  in_cmp_op;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_pc;

    logic        in_ready, out_valid, out_taken, out_misalign, redirect_valid;
    logic [31:0] out_target, out_next_pc, redirect_pc, cnt_resolved, cnt_mispredict;

    logic        d4_in_ready, d4_out_valid, d4_out_taken, d4_out_misalign, d4_redirect_valid;
    logic [31:0] d4_out_target, d4_out_next_pc, d4_redirect_pc;
    logic [3:0]  d4_cnt_resolved, d4_cnt_mispredict;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_cmp_op(in_cmp_op), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_pc(in_pc), .in_pred_taken(in_pred_taken),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_target(out_target), .out_next_pc(out_next_pc), .out_misalign(out_misalign),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .cnt_resolved(cnt_resolved), .cnt_mispredict(cnt_mispredict)
    );

    branch_resolve_unit #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d4_in_ready),
        .in_cmp_op(in_cmp_op), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_pc(in_pc), .in_pred_taken(in_pred_taken),
        .out_valid(d4_out_valid), .out_ready(out_ready), .out_taken(d4_out_taken),
        .out_target(d4_out_target), .out_next_pc(d4_out_next_pc), .out_misalign(d4_out_misalign),
        .redirect_valid(d4_redirect_valid), .redirect_pc(d4_redirect_pc), .flush(flush),
        .cnt_resolved(d4_cnt_resolved), .cnt_mispredict(d4_cnt_mispredict)
    );

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic [31:0] next_pc;
        logic        mis;
        logic        pred;
    } exp_t;

    exp_t        q[$];
    exp_t        exp_last;
    logic        exp_redir;
    logic [31:0] exp_rpc, exp_res, exp_mis;
    logic [3:0]  exp_res4, exp_mis4;
    logic        mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        exp_t e;
        case (op)
            OP_EQ:   e.taken = (a == b);
            OP_NE:   e.taken = (a != b);
            OP_LT:   e.taken = ($signed(a) < $signed(b));
            OP_GE:   e.taken = ($signed(a) >= $signed(b));
            OP_LTU:  e.taken = (a < b);
            OP_GEU:  e.taken = (a >= b);
            default: e.taken = 1'b0;
        endcase
        e.target  = pc + imm;
        e.next_pc = e.taken ? e.target : pc + 32'd4;
        e.mis     = e.taken && (e.target[1:0] != 2'b00);
        e.pred    = pred;
        return e;
    endfunction

    // Checks the registered state each negedge, then advances the model for the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic hs, acc, rdy;
            exp_t e;
            rdy = (q.size() == 0) || out_ready;
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, rdy);
            chk("out_taken", out_taken, exp_last.taken);
            chk("out_target", out_target, exp_last.target);
            chk("out_next_pc", out_next_pc, exp_last.next_pc);
            chk("out_misalign", out_misalign, exp_last.mis);
            chk("redirect_valid", redirect_valid, exp_redir);
            chk("redirect_pc", redirect_pc, exp_rpc);
            chk("cnt_resolved", cnt_resolved, exp_res);
            chk("cnt_mispredict", cnt_mispredict, exp_mis);
            chk("cnt4_resolved", d4_cnt_resolved, exp_res4);
            chk("cnt4_mispredict", d4_cnt_mispredict, exp_mis4);
            if (rst) begin
                q.delete();
                exp_last = '{1'b0, 32'd0, 32'd0, 1'b0, 1'b0};
                exp_redir = 1'b0; exp_rpc = '0;
                exp_res = '0; exp_mis = '0; exp_res4 = '0; exp_mis4 = '0;
            end else begin
                hs  = (q.size() != 0) && out_ready && !flush;
                acc = in_valid && rdy && !flush;
                exp_redir = 1'b0;
                if (flush) begin
                    q.delete();
                end else begin
                    if (hs) begin
                        e = q.pop_front();
                        exp_res++;
                        if (exp_res4 != 4'hF) exp_res4++;
                        if (!e.mis && (e.taken != e.pred)) begin
                            exp_redir = 1'b1;
                            exp_rpc   = e.next_pc;
                            exp_mis++;
                            if (exp_mis4 != 4'hF) exp_mis4++;
                        end
                    end
                    if (acc) begin
                        e = model(in_cmp_op, in_rs1_val, in_rs2_val, in_pc, in_imm, in_pred_taken);
                        q.push_back(e);
                        exp_last = e;
                    end
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        in_valid = 1'b1; in_cmp_op = op; in_rs1_val = a; in_rs2_val = b;
        in_pc = pc; in_imm = imm; in_pred_taken = pred;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        in_cmp_op = OP_NOP; in_rs1_val = '0; in_rs2_val = '0; in_imm = '0; in_pc = '0;
        in_pred_taken = 1'b0;
        cycle();
        mon_en = 1'b1;
        cycle();
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1'b1);

        // BEQ, correctly predicted taken
        drive(OP_EQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1);
        cycle();
        in_valid = 1'b0;
        chk("beq_valid", out_valid, 1'b1);
        chk("beq_taken", out_taken, 1'b1);
        chk("beq_target", out_target, 32'h120);
        cycle();
        chk("beq_no_redirect", redirect_valid, 1'b0);
        chk("beq_cnt", cnt_resolved, 32'd1);

        // BLT signed mispredict, then BLTU not taken
        drive(OP_LT, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0);
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("blt_redirect", redirect_valid, 1'b1);
        chk("blt_redirect_pc", redirect_pc, 32'h240);
        chk("blt_cnt_mis", cnt_mispredict, 32'd1);
        drive(OP_LTU, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0);
        cycle();
        in_valid = 1'b0;
        chk("bltu_taken", out_taken, 1'b0);
        chk("bltu_next_pc", out_next_pc, 32'h204);
        chk("redirect_one_cycle", redirect_valid, 1'b0);
        cycle();

        // Backpressure with a second branch waiting
        out_ready = 1'b0;
        drive(OP_GE, 32'h8000_0000, 32'd3, 32'h300, 32'h10, 1'b1);
        cycle();
        drive(OP_GEU, 32'h8000_0000, 32'd3, 32'h400, 32'hFFFF_FFF0, 1'b0);
        repeat (3) begin
            cycle();
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_stable_np", out_next_pc, 32'h304);
        end
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("bp_second_loaded", out_target, 32'h3F0);
        cycle();
        chk("bp_redirect", redirect_valid, 1'b1);

        // Flush with an entry held and another incoming
        out_ready = 1'b0;
        drive(OP_NE, 32'd1, 32'd2, 32'h500, 32'h8, 1'b0);
        cycle();
        drive(OP_EQ, 32'd1, 32'd1, 32'h600, 32'h8, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_valid", out_valid, 1'b0);
        cycle();
        chk("flush_no_redirect", redirect_valid, 1'b0);

        // Misaligned taken target, then fall-through wrap
        drive(OP_EQ, 32'd7, 32'd7, 32'h100, 32'h2, 1'b0);
        cycle();
        in_valid = 1'b0;
        chk("misalign", out_misalign, 1'b1);
        cycle();
        chk("misalign_no_redirect", redirect_valid, 1'b0);
        drive(OP_NE, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'h20, 1'b0);
        cycle();
        in_valid = 1'b0;
        chk("wrap_next_pc", out_next_pc, 32'h0);

        // NOP and undefined codes resolve not-taken
        drive(OP_NOP, 32'd1, 32'd1, 32'h700, 32'h40, 1'b1);
        cycle();
        drive(OP_BAD, 32'd1, 32'd1, 32'h800, 32'h40, 1'b1);
        cycle();
        in_valid = 1'b0;
        chk("bad_op_redirect_pc", redirect_pc, 32'h704);
        cycle();
        chk("bad_op_redirect_pc2", redirect_pc, 32'h804);

        // Back-to-back mispredicts saturate the narrow counters; flush while pulse is up
        for (int i = 0; i < 20; i++) begin
            drive(OP_EQ, 32'(i), 32'(i), 32'h1000 + 32'(i * 16), 32'h80, 1'b0);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("sat4_mispredict", d4_cnt_mispredict, 4'hF);
        chk("sat4_resolved", d4_cnt_resolved, 4'hF);

        // Reset while stalled
        out_ready = 1'b0;
        drive(OP_EQ, 32'd2, 32'd2, 32'h900, 32'h40, 1'b0);
        cycle();
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_redirect", redirect_valid, 1'b0);
        chk("rst_target", out_target, 32'h0);
        chk("rst_next_pc", out_next_pc, 32'h0);
        chk("rst_cnt_res", cnt_resolved, 32'h0);
        chk("rst_cnt_mis", cnt_mispredict, 32'h0);
        out_ready = 1'b1;
        repeat (3) cycle();

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Execute-stage consumer of the B-type decoder outputs (cmp_op, immediate, rs1/rs2 operand values). Evaluates the branch condition, computes the target, compares the outcome with the fetch-stage prediction, and issues a one-cycle redirect to fetch on a mispredict. Uses one registered pipeline stage with valid/ready handshakes on both sides and a flush input. Keeps saturating resolved and mispredict counters for the perf-counter CSRs.

Parameters:
XLEN, 32, operand/PC/immediate width
CNT_W, 32, width of performance counters

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  decoded branch presented
in_ready  out  1  stage can accept
in_cmp_op  in  3  compare op, shared ALU_CMP_OP_ENUM encoding
in_rs1_val  in  XLEN  operand a
in_rs2_val  in  XLEN  operand b
in_imm  in  XLEN  sign-extended B immediate, bit0 = 0
in_pc  in  XLEN  PC of branch
in_pred_taken  in  1  fetch prediction
out_valid  out  1  resolved result held
out_ready  in  1  downstream accepts
out_taken  out  1  condition result
out_target  out  XLEN  in_pc + in_imm
out_next_pc  out  XLEN  correct next PC: target if taken, else pc+4
out_misalign  out  1  taken and target[1:0] != 0
redirect_valid  out  1  one-cycle fetch redirect pulse
redirect_pc  out  XLEN  redirect address (= out_next_pc of resolved entry)
flush  in  1  kill in-flight and incoming branch
cnt_resolved  out  CNT_W  branches retired through output
cnt_mispredict  out  CNT_W  mispredicts retired

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, redirect_valid=0, all data outputs 0, both counters 0. in_ready=1 in the first cycle after reset.
- in_ready = !out_valid || out_ready (combinational; registered-stage pipeline, no bubble at full throughput).
- Accept occurs when in_valid && in_ready && !flush. On accept, the output register loads on the next edge. Latency is 1 cycle from accept to out_valid.
- Compare: EQ a==b; NE a!=b; LT/GE signed; LTU/GEU unsigned; NOP or an undefined code gives taken=0.
- Target = in_pc + in_imm, modulo 2^XLEN (wrap ignored). Fall-through = in_pc + 4, modulo 2^XLEN.
- out_misalign = taken && target[1:0]!=0. A misaligned entry never redirects and never counts as a mispredict.
- Output handshake fires when out_valid && out_ready. out_valid clears unless a new accept happens in the same cycle. Data is stable while out_valid && !out_ready.
- Mispredict = taken != pred_taken, evaluated at output handshake and excluding misaligned entries. On a mispredict handshake, redirect_valid=1 for exactly the next cycle and redirect_pc = next_pc. Otherwise redirect_valid=0.
- Counters increment on the output handshake: resolved always, mispredict when a redirect is issued. Both saturate at all-ones.
- Flush: the next edge clears out_valid. No handshake is counted that cycle and no redirect is raised. A flush does not cancel a redirect_valid already high; that pulse still completes. Incoming in_valid is dropped.
- Flush has priority over simultaneous accept and handshake. rst has priority over everything.
- Reset asserted mid-operation discards the held entry and any pending redirect on the next edge.

Decomposition:
- Shared package: ALU_CMP_OP_ENUM (existing, no new encodings) and a constant INSTR_BYTES=4.
- One sub-module, branch_compare: combinational cmp_op/a/b -> taken. The stage register, redirect and counters stay in the top.

Test Plan:
1. BEQ: rs1=5, rs2=5, pc=0x100, imm=0x20, pred=1 -> next cycle out_valid=1, taken=1, target=0x120, no redirect, cnt_resolved=1.
2. BLT signed: rs1=0xFFFFFFFF, rs2=1, pred=0 -> taken=1, redirect_valid pulses 1 cycle with redirect_pc=target, cnt_mispredict=1. Same operands with BLTU -> taken=0, next_pc=pc+4.
3. Backpressure: out_ready=0 for 3 cycles with a second in_valid -> in_ready=0, out data stable, second branch accepted in the cycle out_ready rises, back-to-back outputs.
4. Flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, no redirect, counters unchanged.
5. Misalign: pc=0x100, imm=0x2, taken, pred=0 -> out_misalign=1, redirect_valid stays 0, cnt_mispredict unchanged. Wrap: pc=0xFFFFFFFC, not taken -> next_pc=0x0.
6. Reset mid-stall with out_valid=1 -> all outputs 0 after the edge. Counters preloaded near max via repeated mispredicts saturate at 0xFFFFFFFF (CNT_W=4 variant: saturate at 0xF).
